// File: rtl/alu_seq_pkg.sv
// Shared op codes and FSM state encoding for the sequential ALU.
package alu_pkg;
  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD      = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB      = 6'd1;
  localparam logic [OP_W-1:0] OP_SHL      = 6'd2;
  localparam logic [OP_W-1:0] OP_SHR      = 6'd3;
  localparam logic [OP_W-1:0] OP_PASS     = 6'd4;
  localparam logic [OP_W-1:0] OP_LOADHALF = 6'd5;
  localparam logic [OP_W-1:0] OP_EQ       = 6'd8;
  localparam logic [OP_W-1:0] OP_LT       = 6'd9;
  localparam logic [OP_W-1:0] OP_GT       = 6'd10;
  localparam logic [OP_W-1:0] OP_NF1      = 6'd11;
  localparam logic [OP_W-1:0] OP_AND12    = 6'd12;
  localparam logic [OP_W-1:0] OP_F1       = 6'd13;
  localparam logic [OP_W-1:0] OP_MUL      = 6'd16;
  localparam logic [OP_W-1:0] OP_AND      = 6'd17;
  localparam logic [OP_W-1:0] OP_OR       = 6'd18;
  localparam logic [OP_W-1:0] OP_XOR      = 6'd19;

  typedef enum logic {IDLE, MUL} state_t;
endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between register read, the ALU and write-back.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
);
  logic                 in_valid;
  logic                 in_ready;
  logic [OP_W-1:0]      op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [WIDTH/2-1:0]   imm;
  logic                 highlow;
  logic                 flag_in1;
  logic                 flag_in2;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic                 flag_out;
  logic                 busy;

  modport master (
    output in_valid, op, a, b, imm, highlow, flag_in1, flag_in2, out_ready,
    input  in_ready, out_valid, result, flag_out, busy
  );

  modport slave (
    input  in_valid, op, a, b, imm, highlow, flag_in1, flag_in2, out_ready,
    output in_ready, out_valid, result, flag_out, busy
  );
endinterface

// File: rtl/alu_seq_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per clock, WIDTH clocks after start.
module alu_mul_iter #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
  logic [CW-1:0]    cnt;
  logic             run;

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  // done is combinational so the final partial product lands in the caller's register on the same edge
  assign done     = run && (cnt == CW'(WIDTH-1));
  assign product  = acc_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides; MUL iterates and stalls the input side.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int MUL_EN = 1
) (
  input  logic     clock,
  input  logic     reset_n,
  alu_seq_if.slave bus
);
  localparam int HW = WIDTH / 2;
  localparam int SW = $clog2(WIDTH);

  state_t           state;
  logic             out_valid, flag_out, busy;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] res_c;
  logic             flag_c, big_sh, is_mul, fire_in, fire_out, in_ready;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign in_ready      = (state == IDLE) && (!out_valid || bus.out_ready);
  assign fire_in       = bus.in_valid && in_ready;
  assign fire_out      = out_valid && bus.out_ready;
  assign is_mul        = (MUL_EN != 0) && (bus.op == OP_MUL);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = result;
  assign bus.flag_out  = flag_out;
  assign bus.busy      = busy;

  always_comb begin
    res_c  = '0;
    flag_c = 1'b0;
    big_sh = bus.b >= WIDTH'(WIDTH);
    case (bus.op)
      OP_ADD:      res_c = bus.a + bus.b;
      OP_SUB:      res_c = bus.a + ~bus.b + 1'b1;
      // shifting the complement and re-inverting fills vacated bits with ones
      OP_SHL:      res_c = big_sh ? '1 : ~((~bus.a) << bus.b[SW-1:0]);
      OP_SHR:      res_c = big_sh ? '1 : ~((~bus.a) >> bus.b[SW-1:0]);
      OP_PASS, 6'd6, 6'd7: res_c = bus.a;
      OP_LOADHALF: res_c = bus.highlow ? {bus.imm, bus.a[HW-1:0]}
                                       : {bus.a[WIDTH-1:HW], bus.imm};
      OP_EQ:       flag_c = (bus.a == bus.b);
      OP_LT:       flag_c = (bus.a <  bus.b);
      OP_GT:       flag_c = (bus.a >  bus.b);
      OP_NF1:      flag_c = !bus.flag_in1;
      OP_AND12:    flag_c = bus.flag_in1 && bus.flag_in2;
      OP_F1:       flag_c = bus.flag_in1;
      OP_AND:      res_c = bus.a & bus.b;
      OP_OR:       res_c = bus.a | bus.b;
      OP_XOR:      res_c = bus.a ^ bus.b;
      default:     res_c = '0;
    endcase
  end

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (fire_in && is_mul),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_prod)
      );
    end else begin : g_nomul
      assign mul_done = 1'b0;
      assign mul_prod = '0;
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flag_out  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fire_in) begin
            if (is_mul) begin
              // any prior result is firing this edge, so the output goes empty while iterating
              state     <= MUL;
              busy      <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              result    <= res_c;
              flag_out  <= flag_c;
              out_valid <= 1'b1;
            end
          end else if (fire_out) begin
            out_valid <= 1'b0;
          end
        end
        MUL: begin
          if (mul_done) begin
            result    <= mul_prod;
            flag_out  <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Table-driven bench with an output scoreboard plus MUL, reset-abort and backpressure sequences.
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct {
    logic [5:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [31:0] imm;
    logic        hl;
    logic        f1;
    logic        f2;
    logic [63:0] res;
    logic        flag;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic        flag;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  vec_t tbl[$];

  always #5 clock = ~clock;

  alu_seq_if #(.WIDTH(64)) bus ();

  alu_seq #(.WIDTH(64), .MUL_EN(1)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output side: every fire is checked against the oldest expected entry.
  always @(negedge clock) begin
    #2;
    if (reset_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %h expected none", bus.result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", bus.result, e.res);
        chk("sb_flag", {63'd0, bus.flag_out}, {63'd0, e.flag});
      end
    end
  end

  // Called right after a negedge; returns at the negedge after the accepting edge.
  task automatic send(input vec_t v, input bit push);
    bit ok;
    bus.in_valid = 1'b1;
    bus.op       = v.op;
    bus.a        = v.a;
    bus.b        = v.b;
    bus.imm      = v.imm;
    bus.highlow  = v.hl;
    bus.flag_in1 = v.f1;
    bus.flag_in2 = v.f2;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
      #1;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end else if (push) begin
      sb.push_back('{res: v.res, flag: v.flag});
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clock);
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  function automatic vec_t mk(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                              input logic [31:0] imm, input logic hl, input logic f1,
                              input logic f2, input logic [63:0] res, input logic flag);
    vec_t v;
    v = '{op: op, a: a, b: b, imm: imm, hl: hl, f1: f1, f2: f2, res: res, flag: flag};
    return v;
  endfunction

  initial begin
    vec_t v;
    int   bad;

    tbl.push_back(mk(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 0, 0, 0, 64'd0, 0));
    tbl.push_back(mk(OP_SUB, 64'd5, 64'd7, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0));
    tbl.push_back(mk(OP_SHL, 64'd0, 64'd4, 0, 0, 0, 0, 64'h0000_0000_0000_000F, 0));
    tbl.push_back(mk(OP_SHR, 64'd0, 64'd4, 0, 0, 0, 0, 64'hF000_0000_0000_0000, 0));
    tbl.push_back(mk(OP_SHL, 64'd0, 64'd64, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0));
    tbl.push_back(mk(OP_SHR, 64'd5, 64'd100, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0));
    tbl.push_back(mk(OP_SHL, 64'h8000_0000_0000_0001, 64'd1, 0, 0, 0, 0, 64'd3, 0));
    tbl.push_back(mk(OP_LOADHALF, 64'h1111_1111_2222_2222, 0, 32'hABCDEF01, 0, 0, 0,
                     64'h1111_1111_ABCD_EF01, 0));
    tbl.push_back(mk(OP_LOADHALF, 64'h1111_1111_2222_2222, 0, 32'hABCDEF01, 1, 0, 0,
                     64'hABCD_EF01_2222_2222, 0));
    tbl.push_back(mk(OP_PASS, 64'h1234, 64'd9, 0, 0, 0, 0, 64'h1234, 0));
    tbl.push_back(mk(6'd6, 64'hBEEF, 64'd9, 0, 0, 0, 0, 64'hBEEF, 0));
    tbl.push_back(mk(6'd7, 64'hDEAD, 64'd9, 0, 0, 0, 0, 64'hDEAD, 0));
    tbl.push_back(mk(OP_EQ, 64'd9, 64'd9, 0, 0, 0, 0, 64'd0, 1));
    tbl.push_back(mk(OP_EQ, 64'd9, 64'd8, 0, 0, 0, 0, 64'd0, 0));
    tbl.push_back(mk(OP_LT, 64'd3, 64'd4, 0, 0, 0, 0, 64'd0, 1));
    tbl.push_back(mk(OP_GT, 64'd3, 64'd4, 0, 0, 0, 0, 64'd0, 0));
    tbl.push_back(mk(OP_GT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4, 0, 0, 0, 0, 64'd0, 1));
    tbl.push_back(mk(OP_NF1, 64'd1, 64'd1, 0, 0, 0, 0, 64'd0, 1));
    tbl.push_back(mk(OP_AND12, 64'd1, 64'd1, 0, 0, 1, 0, 64'd0, 0));
    tbl.push_back(mk(OP_AND12, 64'd1, 64'd1, 0, 0, 1, 1, 64'd0, 1));
    tbl.push_back(mk(OP_F1, 64'd1, 64'd1, 0, 0, 1, 0, 64'd0, 1));
    tbl.push_back(mk(OP_AND, 64'hF0F0, 64'hFF00, 0, 0, 0, 0, 64'hF000, 0));
    tbl.push_back(mk(OP_OR,  64'hF0F0, 64'hFF00, 0, 0, 0, 0, 64'hFFF0, 0));
    tbl.push_back(mk(OP_XOR, 64'hF0F0, 64'hFF00, 0, 0, 0, 0, 64'h0FF0, 0));
    tbl.push_back(mk(6'd63, 64'd5, 64'd5, 0, 0, 1, 1, 64'd0, 0));
    tbl.push_back(mk(6'd14, 64'd5, 64'd5, 0, 0, 1, 1, 64'd0, 0));

    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.imm       = '0;
    bus.highlow   = 1'b0;
    bus.flag_in1  = 1'b0;
    bus.flag_in2  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_flag", {63'd0, bus.flag_out}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    #1;
    chk("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clock);

    // single-cycle latency on the ADD wrap case
    send(tbl[0], 1'b1);
    idle();
    #1;
    chk("lat_out_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("lat_result", bus.result, 64'd0);
    @(negedge clock);
    drain();

    // back-to-back table sweep
    foreach (tbl[i]) send(tbl[i], 1'b1);
    idle();
    drain();

    // MUL: 64 busy cycles, operand changes ignored
    @(negedge clock);
    v = mk(OP_MUL, 64'h1_0000_0001, 64'd3, 0, 0, 0, 0, 64'h3_0000_0003, 0);
    send(v, 1'b1);
    idle();
    bus.a  = '1;
    bus.b  = '1;
    bus.op = OP_ADD;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (!(bus.busy && !bus.in_ready && !bus.out_valid)) bad++;
      @(negedge clock);
    end
    chk("mul_busy_cycles", 64'(bad), 64'd0);
    #1;
    chk("mul_busy_clear", {63'd0, bus.busy}, 64'd0);
    chk("mul_out_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("mul_result", bus.result, 64'h3_0000_0003);
    @(negedge clock);
    drain();

    // MUL aborted by reset: no result may ever appear
    @(negedge clock);
    send(v, 1'b0);
    idle();
    repeat (9) @(negedge clock);
    #1;
    chk("abort_busy_before", {63'd0, bus.busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clock);
      #1;
      if (bus.out_valid) bad++;
    end
    chk("abort_no_result", 64'(bad), 64'd0);
    @(negedge clock);

    // backpressure: hold the first result, then stream the rest
    bus.out_ready = 1'b0;
    send(mk(OP_ADD, 64'd1, 64'd1, 0, 0, 0, 0, 64'd2, 0), 1'b1);
    bus.op = OP_ADD;
    bus.a  = 64'd2;
    bus.b  = 64'd2;
    repeat (4) @(negedge clock);
    #1;
    chk("bp_hold_result", bus.result, 64'd2);
    chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
    bus.out_ready = 1'b1;
    send(mk(OP_ADD, 64'd2, 64'd2, 0, 0, 0, 0, 64'd4, 0), 1'b1);
    chk("bp_second", bus.result, 64'd4);
    send(mk(OP_ADD, 64'd3, 64'd3, 0, 0, 0, 0, 64'd6, 0), 1'b1);
    idle();
    chk("bp_third", bus.result, 64'd6);
    @(negedge clock);
    drain();

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
